// File: rtl/pulse_train_gen.sv
// pulse_train_gen: programmable pulse-train transmitter.
// Emits N pulses on sign_o, each high for H cycles then low for L cycles,
// so every pulse ends in exactly one registered falling edge.
// Ports:
//   clk_i        single clock, rising edge
//   rstn_i       synchronous active-low reset
//   start_i      burst request, sampled only in IDLE
//   stop_i       abort request, sampled every cycle
//   high_len_i   high time per pulse in cycles (0 acts as 1)
//   low_len_i    low time per pulse in cycles (0 acts as 1)
//   pulse_num_i  pulses per burst (0 = continuous until stop)
//   sign_o       generated pulse line
//   busy_o       burst in progress
//   done_o       one-cycle strobe after the last LOW phase of a counted burst
//   pulse_cnt_o  falling edges emitted since the last accepted start
module pulse_train_gen #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NUM_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] high_len_i,
  input  logic [CNT_W-1:0] low_len_i,
  input  logic [NUM_W-1:0] pulse_num_i,
  output logic             sign_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [NUM_W-1:0] pulse_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] high_q,  high_d;
  logic [CNT_W-1:0] low_q,   low_d;
  logic [NUM_W-1:0] num_q,   num_d;
  logic [NUM_W-1:0] pcnt_q,  pcnt_d;
  logic             sign_q,  sign_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic [CNT_W-1:0] high_eff_c;
  logic [CNT_W-1:0] low_eff_c;

  // Zero lengths are promoted to one cycle so every phase is visible.
  assign high_eff_c = (high_len_i == '0) ? CNT_W'(1) : high_len_i;
  assign low_eff_c  = (low_len_i  == '0) ? CNT_W'(1) : low_len_i;

  // Next-state and output decode; phase_q counts down remaining cycles - 1.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    high_d  = high_q;
    low_d   = low_q;
    num_d   = num_q;
    pcnt_d  = pcnt_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          high_d  = high_eff_c;
          low_d   = low_eff_c;
          num_d   = pulse_num_i;
          pcnt_d  = '0;
          phase_d = high_eff_c - CNT_W'(1);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (stop_i) begin
          // Forced drop is not a counted pulse.
          state_d = IDLE;
        end else if (phase_q == '0) begin
          state_d = LOW;
          phase_d = low_q - CNT_W'(1);
          pcnt_d  = pcnt_q + NUM_W'(1);
        end else begin
          phase_d = phase_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (phase_q == '0) begin
          if ((num_q != '0) && (pcnt_q == num_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = HIGH;
            phase_d = high_q - CNT_W'(1);
          end
        end else begin
          phase_d = phase_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    sign_d = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      phase_q <= '0;
      high_q  <= '0;
      low_q   <= '0;
      num_q   <= '0;
      pcnt_q  <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      high_q  <= high_d;
      low_q   <= low_d;
      num_q   <= num_d;
      pcnt_q  <= pcnt_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sign_o      = sign_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pulse_cnt_o = pcnt_q;

endmodule
